// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - machine width and instruction size
//   - RV32I major opcode constants (used by decode/control alongside fetch)
//   - fetch FSM state encoding
//   - buffer entry layout and PC helpers
package inst_fetch_unit_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_ECALL    = 7'b111_0011;

  // Full ecall encoding, for decode to recognise the halt request
  localparam logic [XLEN-1:0] INST_ECALL = 32'h0000_0073;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// Small synchronous FIFO holding fetched {inst, pc} pairs.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 empty the FIFO this cycle (overrides push/pop)
//   push, push_inst/pc    write a new entry at the tail
//   pop                   drop the head entry (ignored when empty)
//   head_valid/inst/pc    head entry; data reads 0 when empty
//   count                 current occupancy, used by the top for credits
module inst_fetch_unit_fetch_buffer
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [XLEN-1:0]  push_inst,
  input  logic [XLEN-1:0]  push_pc,
  input  logic             pop,
  output logic             head_valid,
  output logic [XLEN-1:0]  head_inst,
  output logic [XLEN-1:0]  head_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid = (count != '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign do_pop     = pop && head_valid;
  // Gate with valid so the head never shows stale or reset-undefined data.
  assign head_inst  = head_valid ? mem[rd_ptr].inst : '0;
  assign head_pc    = head_valid ? mem[rd_ptr].pc   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through head_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{inst: push_inst, pc: push_pc};
  end

  // Credits keep pushes off a full FIFO unless the head leaves the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, collects
// in-order responses into a small buffer and presents {inst, inst_pc} to
// decode. Handles redirects (flush + restart) and the ecall halt.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   imem_req_valid/ready/addr            fetch request channel
//   imem_resp_valid/data                 in-order response (no back-pressure)
//   inst_valid/ready, inst, inst_pc      instruction channel to decode
//   redirect_valid, redirect_pc          flush and restart at a new PC
//   halt                                 ecall retired, stop fetching
//   halted                               in HALT with nothing outstanding
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | one cycle after reset before fetching starts
// FETCH | issuing requests whenever credits allow
// HALT  | no new requests; in-flight words still land in the buffer
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   credits_used;
  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;

  assign redirect_target = align_pc(redirect_pc);

  // Every slot is either buffered or reserved by a request still in flight,
  // so the buffer can never be overrun by a returning response.
  assign credits_used = {1'b0, outstanding} + {1'b0, occupancy};
  assign credit_ok    = credits_used < (CNT_W + 1)'(BUF_DEPTH);

  assign imem_req_valid = (state == FETCH) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;

  // Responses during a redirect, or owed to an earlier redirect, are dropped.
  assign push = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
  assign pop  = inst_valid && inst_ready;

  assign halted = (state == HALT) && (outstanding == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case ({issue, imem_resp_valid})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase

      if (redirect_valid) begin
        // No issue can happen this cycle, so whatever is still in flight
        // after this edge belongs to the old stream and must be discarded.
        state    <= FETCH;
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= imem_resp_valid ? outstanding - CNT_W'(1) : outstanding;
      end else begin
        if (issue) fetch_pc <= next_pc(fetch_pc);
        if (imem_resp_valid) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
          else                resp_pc  <= next_pc(resp_pc);
        end
        case (state)
          IDLE:    state <= FETCH;
          FETCH:   if (halt) state <= HALT;
          HALT:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  inst_fetch_unit_fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (reset_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_inst  (imem_resp_data),
    .push_pc    (resp_pc),
    .pop        (pop),
    .head_valid (inst_valid),
    .head_inst  (inst),
    .head_pc    (inst_pc),
    .count      (occupancy)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  inst_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Memory: in-order, one response per cycle, per-request latency.
  // Fetch: each request carries the stream epoch it was issued in; a
  // redirect bumps the epoch, and stale-epoch responses never reach the
  // instruction queue.
  typedef struct { int due; logic [31:0] addr; int epoch; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

  req_t        infl[$];
  ent_t        mbuf[$];
  int          mode;        // 0 idle, 1 fetching, 2 halted
  int          epoch;
  int          last_due;
  int          cyc;
  logic [31:0] m_fetch;

  int n_cmp = 0;
  int n_err = 0;

  logic        s_rv, s_iv, s_hd;
  logic [31:0] s_addr, s_ipc, s_inst;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a * 32'h0019_660D + 32'h3C6E_F35F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not seen within budget (cycle %0d)", name, cyc);
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic step(input bit ir, input bit rr, input bit rd, input logic [31:0] rpc,
                      input bit h, input int lat);
    req_t e;
    bit   resp_now, exp_rv, exp_iv, exp_hd, issue;
    int   due;
    resp_now        = (infl.size() > 0) && (infl[0].due == cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? memfn(infl[0].addr) : 32'h0;
    inst_ready      = ir;
    imem_req_ready  = rr;
    redirect_valid  = rd;
    redirect_pc     = rpc;
    halt            = h;
    @(negedge clk);
    s_rv = imem_req_valid; s_addr = imem_req_addr;
    s_iv = inst_valid;     s_ipc  = inst_pc;  s_inst = inst;
    s_hd = halted;
    exp_rv = (mode == 1) && !rd && (infl.size() + mbuf.size() < DEPTH);
    exp_iv = (mbuf.size() != 0);
    exp_hd = (mode == 2) && (infl.size() == 0);
    chk("req_valid", 32'(s_rv), 32'(exp_rv));
    if (exp_rv && s_rv) chk("req_addr", s_addr, m_fetch);
    chk("inst_valid", 32'(s_iv), 32'(exp_iv));
    if (exp_iv && s_iv) begin
      chk("inst_pc", s_ipc, mbuf[0].pc);
      chk("inst", s_inst, mbuf[0].inst);
    end
    chk("halted", 32'(s_hd), 32'(exp_hd));
    issue = exp_rv && rr;
    e = '{due: 0, addr: 32'h0, epoch: -1};
    if (resp_now) e = infl.pop_front();
    if (rd) begin
      mbuf.delete();
      epoch++;
      m_fetch = {rpc[31:2], 2'b00};
      mode = 1;
    end else begin
      if (exp_iv && ir) void'(mbuf.pop_front());
      if (resp_now && e.epoch == epoch) mbuf.push_back('{inst: memfn(e.addr), pc: e.addr});
      if (issue) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        infl.push_back('{due: due, addr: m_fetch, epoch: epoch});
        m_fetch = m_fetch + 32'd4;
      end
      if (mode == 0) mode = 1;
      else if (mode == 1 && h) mode = 2;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset asynchronously, checks outputs without a clock edge, and
  // releases just after a rising edge.
  task automatic do_reset();
    reset_n = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
    infl.delete(); mbuf.delete();
    mode = 0; epoch = 0; last_due = -1; cyc = 0; m_fetch = RST_PC;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_req(input logic [31:0] exp, input bit ir, input int lat);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(ir, 1, 0, 32'h0, 0, lat);
      if (s_rv) begin
        found = 1;
        chk("next_req_addr", s_addr, exp);
      end
    end
    if (!found) timeout("wait_req");
  endtask

  task automatic wait_inst(input logic [31:0] exp, input int lat);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 1, 0, 32'h0, 0, lat);
      if (s_iv) begin
        found = 1;
        chk("next_inst_pc", s_ipc, exp);
        chk("next_inst", s_inst, memfn(exp));
      end
    end
    if (!found) timeout("wait_inst");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit ir; bit rv; logic [31:0] addr; bit iv; logic [31:0] ipc;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit rst, input bit ir, input bit rv, input logic [31:0] addr,
                     input bit iv, input logic [31:0] ipc);
    tv.push_back('{rst: rst, ir: ir, rv: rv, addr: addr, iv: iv, ipc: ipc});
  endtask

  int nreq;

  initial begin
    reset_n = 1'b0;
    // stream: 1-cycle memory, decode always ready
    add(1, 1, 0, 0,     0, 0);
    add(0, 1, 1, 32'h0, 0, 0);
    add(0, 1, 1, 32'h4, 0, 0);
    add(0, 1, 0, 0,     1, 32'h0);
    add(0, 1, 1, 32'h8, 1, 32'h4);
    add(0, 1, 1, 32'hC, 0, 0);
    add(0, 1, 0, 0,     1, 32'h8);
    add(0, 1, 1, 32'h10, 1, 32'hC);
    // back-pressure: two requests fill the buffer, then release
    add(1, 0, 0, 0,     0, 0);
    add(0, 0, 1, 32'h0, 0, 0);
    add(0, 0, 1, 32'h4, 0, 0);
    add(0, 0, 0, 0,     1, 32'h0);
    add(0, 0, 0, 0,     1, 32'h0);
    add(0, 0, 0, 0,     1, 32'h0);
    add(0, 1, 0, 0,     1, 32'h0);
    add(0, 1, 1, 32'h8, 1, 32'h4);
    add(0, 1, 1, 32'hC, 0, 0);
    add(0, 1, 0, 0,     1, 32'h8);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      step(tv[i].ir, 1, 0, 32'h0, 0, 1);
      chk("tbl_req_valid", 32'(s_rv), 32'(tv[i].rv));
      if (tv[i].rv) chk("tbl_req_addr", s_addr, tv[i].addr);
      chk("tbl_inst_valid", 32'(s_iv), 32'(tv[i].iv));
      if (tv[i].iv) chk("tbl_inst_pc", s_ipc, tv[i].ipc);
      chk("tbl_halted", 32'(s_hd), 32'd0);
    end

    // redirect with 0x8 and 0xC in flight (latency 3)
    do_reset();
    wait_req(32'h0, 1, 3);
    wait_req(32'h4, 1, 3);
    wait_req(32'h8, 1, 3);
    wait_req(32'hC, 1, 3);
    step(1, 1, 1, 32'h103, 0, 3);
    chk("redir_req_suppressed", 32'(s_rv), 32'd0);
    wait_req(32'h100, 1, 3);
    wait_inst(32'h100, 3);
    chk("redir_drop_cnt", 32'(dut.drop_cnt), 32'd0);

    // redirect in the same cycle as the 0x4 response, 0x8 still in flight
    do_reset();
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);   // 0x0 issued, returns next cycle
    step(1, 1, 0, 0, 0, 4);   // 0x4 issued, returns in cycle 6
    step(1, 1, 0, 0, 0, 4);
    step(1, 1, 0, 0, 0, 4);   // 0x8 issued
    chk("coin_req_8", s_addr, 32'h8);
    step(1, 1, 0, 0, 0, 4);
    step(1, 1, 1, 32'h40, 0, 1);
    chk("coin_resp_in_redirect", 32'(imem_resp_valid), 32'd1);
    wait_inst(32'h40, 1);
    chk("coin_drop_cnt", 32'(dut.drop_cnt), 32'd0);

    // halt with one request in flight, then redirect out of HALT
    do_reset();
    step(0, 1, 0, 0, 0, 3);
    step(0, 1, 0, 0, 1, 3);
    chk("halt_last_req", 32'(s_rv), 32'd1);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0, 3);
      if (s_rv) nreq++;
    end
    chk("halt_no_req", 32'(nreq), 32'd0);
    chk("halt_halted", 32'(s_hd), 32'd1);
    chk("halt_inst_valid", 32'(s_iv), 32'd1);
    chk("halt_inst_pc", s_ipc, 32'h0);
    step(0, 1, 1, 32'h200, 0, 1);
    wait_req(32'h200, 0, 1);

    // reset while the buffer is full
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 2);
    chk("pre_reset_full", 32'(dut.u_buf.count), 32'd2);
    do_reset();
    wait_req(RST_PC, 1, 1);
    wait_inst(RST_PC, 1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          r_rd, r_h, r_ir, r_rr;
      logic [31:0] r_pc;
      int          r_lat;
      r_rd  = ($urandom_range(0, 99) < 4);
      r_h   = ($urandom_range(0, 99) < 3);
      r_ir  = ($urandom_range(0, 99) < 70);
      r_rr  = ($urandom_range(0, 99) < 75);
      r_lat = $urandom_range(1, 4);
      r_pc  = $urandom;
      if ($urandom_range(0, 9) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
      step(r_ir, r_rr, r_rd, r_pc, r_h, r_lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
